// File: rtl/dac_xfer_pkg.sv
// Shared widths for the DAC/ADC beat transfer blocks.
// Slice ordering helper is shared by the stacker and the splitter.
package dac_xfer_pkg;
  localparam int SAMPLE_WIDTH         = 16;
  localparam int SAMPLES_PER_ADC_BEAT = 8;
  localparam int ADC_BEAT_WIDTH       = SAMPLE_WIDTH * SAMPLES_PER_ADC_BEAT;
  localparam int DAC_BEAT_WIDTH       = 2 * ADC_BEAT_WIDTH;
  localparam int DAC_ADC_RATIO        = DAC_BEAT_WIDTH / ADC_BEAT_WIDTH;

  function automatic int slice_index(input int cnt, input int ratio, input bit reverse);
    return reverse ? (ratio - 1 - cnt) : cnt;
  endfunction
endpackage

// File: rtl/dac_split_x2_if.sv
// AXI4-Stream style beat bundle; tfirst marks the first slice of a wide beat.
interface dac_split_x2_if
  import dac_xfer_pkg::*;
#(
  parameter int WIDTH = ADC_BEAT_WIDTH
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tfirst;

  modport master (output tdata, output tvalid, output tfirst, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_skid_reg.sv
// Skid register with registered ready: one spare beat behind a downstream holding register.
module axis_skid_reg #(
  parameter int WIDTH = 256
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             drain,
  output logic             in_ready,
  output logic             accept,
  output logic             full,
  output logic [WIDTH-1:0] data
);
  logic full_nxt;

  assign accept = in_valid & in_ready;

  // drain: downstream reloads this cycle, so S empties or the input bypasses it
  always_comb begin
    full_nxt = full;
    if (drain)       full_nxt = 1'b0;
    else if (accept) full_nxt = 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      full     <= 1'b0;
      in_ready <= 1'b0;
      data     <= '0;
    end else begin
      full     <= full_nxt;
      in_ready <= ~full_nxt;
      if (accept & ~drain) data <= in_data;
    end
  end
endmodule

// File: rtl/dac_split_x2.sv
// Width down-converter: each wide input beat leaves as RATIO narrow beats, full backpressure.
// H holds the beat being emitted; the skid register catches one more while H is busy.
module dac_split_x2
  import dac_xfer_pkg::*;
#(
  parameter int IN_WIDTH = DAC_BEAT_WIDTH,
  parameter int RATIO    = DAC_ADC_RATIO,
  parameter int REVERSE  = 0
) (
  input  logic          aclk,
  input  logic          areset,
  dac_split_x2_if.slave  s_axis,
  dac_split_x2_if.master m_axis
);
  localparam int OUT_WIDTH = IN_WIDTH / RATIO;
  localparam int CW        = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [IN_WIDTH-1:0]  h_data;
  logic [IN_WIDTH-1:0]  s_data;
  logic                 h_valid;
  logic                 s_full;
  logic                 s_ready;
  logic                 accept;
  logic                 h_done;
  logic                 h_load;
  logic [CW-1:0]        cnt;
  logic [OUT_WIDTH-1:0] m_data;
  int                   slice;

  assign h_done = h_valid & m_axis.tready & (cnt == CW'(RATIO - 1));
  assign h_load = ~h_valid | h_done;

  axis_skid_reg #(.WIDTH(IN_WIDTH)) u_skid (
    .aclk     (aclk),
    .areset   (areset),
    .in_data  (s_axis.tdata),
    .in_valid (s_axis.tvalid),
    .drain    (h_load),
    .in_ready (s_ready),
    .accept   (accept),
    .full     (s_full),
    .data     (s_data)
  );

  assign s_axis.tready = s_ready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      h_data  <= '0;
      h_valid <= 1'b0;
      cnt     <= '0;
    end else if (h_load) begin
      cnt <= '0;
      if (s_full) begin
        h_data  <= s_data;
        h_valid <= 1'b1;
      end else if (accept) begin
        h_data  <= s_axis.tdata;
        h_valid <= 1'b1;
      end else begin
        h_valid <= 1'b0;
      end
    end else if (m_axis.tready) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    m_data = '0;
    slice  = slice_index(int'(cnt), RATIO, REVERSE != 0);
    for (int i = 0; i < RATIO; i++)
      if (slice == i) m_data = h_data[i*OUT_WIDTH +: OUT_WIDTH];
  end

  assign m_axis.tdata  = m_data;
  assign m_axis.tvalid = h_valid;
  assign m_axis.tfirst = h_valid & (cnt == '0);
endmodule

// File: tb/tb_dac_split_x2.sv
// Scoreboarded bench for dac_split_x2: directed beats, stall, reset-mid-beat, reversed slicing.
module tb_dac_split_x2;
  typedef struct {
    logic [127:0] d;
    logic         f;
  } exp_t;

  logic aclk = 1'b0;
  logic areset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_out = 0;
  exp_t exp_q[$];

  logic         ramp_on = 1'b0;
  logic         have_last = 1'b0;
  int           last_hs = 0;
  int           gaps = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = '0;
  logic         prev_first = 1'b0;

  dac_split_x2_if #(.WIDTH(256)) s0 ();
  dac_split_x2_if #(.WIDTH(128)) m0 ();
  dac_split_x2_if #(.WIDTH(256)) s1 ();
  dac_split_x2_if #(.WIDTH(128)) m1 ();

  dac_split_x2 #(.REVERSE(0)) dut (
    .aclk   (aclk),
    .areset (areset),
    .s_axis (s0.slave),
    .m_axis (m0.master)
  );

  dac_split_x2 #(.REVERSE(1)) dut_rev (
    .aclk   (aclk),
    .areset (areset),
    .s_axis (s1.slave),
    .m_axis (m1.master)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: retire output handshakes first, then record newly accepted input beats.
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall hold valid", m0.tvalid, 1'b1);
        chk("stall hold data", m0.tdata, prev_data);
        chk("stall hold tfirst", m0.tfirst, prev_first);
      end
      prev_stall = m0.tvalid & ~m0.tready;
      prev_data  = m0.tdata;
      prev_first = m0.tfirst;
      if (m0.tvalid && m0.tready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected output", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out data", m0.tdata, e.d);
          chk("out tfirst", m0.tfirst, e.f);
        end
        if (ramp_on) begin
          if (have_last && cyc != last_hs + 1) gaps++;
          last_hs   = cyc;
          have_last = 1'b1;
        end
      end
      if (s0.tvalid && s0.tready) begin
        exp_q.push_back('{d: s0.tdata[127:0],   f: 1'b1});
        exp_q.push_back('{d: s0.tdata[255:128], f: 1'b0});
      end
    end
  end

  task automatic send_beat(input logic [255:0] d, output int acc_cyc);
    int t;
    t = 0;
    acc_cyc = -1;
    s0.tdata  = d;
    s0.tvalid = 1'b1;
    while (acc_cyc < 0 && t < 200) begin
      @(negedge aclk);
      if (s0.tready) acc_cyc = cyc;
      @(posedge aclk); #1;
      t++;
    end
    s0.tvalid = 1'b0;
    if (acc_cyc < 0) chk("send timeout", 1'b0, 1'b1);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge aclk);
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d;
    int           t_acc;
    int           prev_acc;
    int           acc;
    int           out0;

    areset = 1'b1;
    s0.tdata = '0; s0.tvalid = 1'b0; s0.tfirst = 1'b0;
    s1.tdata = '0; s1.tvalid = 1'b0; s1.tfirst = 1'b0;
    m0.tready = 1'b1;
    m1.tready = 1'b1;

    // reset values
    #12;
    chk("reset s_tready", s0.tready, 1'b0);
    chk("reset m_tvalid", m0.tvalid, 1'b0);
    chk("reset m_tfirst", m0.tfirst, 1'b0);
    chk("reset m_tdata", m0.tdata, 128'h0);

    // first beat straight out of reset: samples 1..16
    d = 256'h0010_000f_000e_000d_000c_000b_000a_0009_0008_0007_0006_0005_0004_0003_0002_0001;
    s0.tdata  = d;
    s0.tvalid = 1'b1;
    #11 areset = 1'b0;
    #1;
    chk("ready before first edge", s0.tready, 1'b0);
    @(posedge aclk); #1;
    chk("ready after first edge", s0.tready, 1'b1);
    send_beat(d, t_acc);
    chk("first slice valid", m0.tvalid, 1'b1);
    chk("first slice data", m0.tdata, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("first slice tfirst", m0.tfirst, 1'b1);
    @(posedge aclk); #1;
    chk("second slice data", m0.tdata, 128'h0010_000f_000e_000d_000c_000b_000a_0009);
    chk("second slice tfirst", m0.tfirst, 1'b0);
    drain("drain first beat");

    // reversed slice order on the second instance
    s1.tdata  = {{8{16'hAAAA}}, {8{16'h5555}}};
    s1.tvalid = 1'b1;
    @(negedge aclk);
    chk("rev ready", s1.tready, 1'b1);
    @(posedge aclk); #1;
    s1.tvalid = 1'b0;
    chk("rev first data", m1.tdata, {8{16'hAAAA}});
    chk("rev first tfirst", m1.tfirst, 1'b1);
    @(posedge aclk); #1;
    chk("rev second data", m1.tdata, {8{16'h5555}});
    chk("rev second tfirst", m1.tfirst, 1'b0);
    chk("rev second valid", m1.tvalid, 1'b1);
    @(posedge aclk); #1;
    chk("rev idle", m1.tvalid, 1'b0);

    // continuous ramp: accepts every other cycle, no output bubbles
    ramp_on   = 1'b1;
    have_last = 1'b0;
    gaps      = 0;
    prev_acc  = 0;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 16; k++) d[k*16 +: 16] = 16'(b*16 + k);
      send_beat(d, t_acc);
      if (b >= 2) chk("ramp accept spacing", 32'(t_acc - prev_acc), 32'd2);
      prev_acc = t_acc;
    end
    drain("drain ramp");
    ramp_on = 1'b0;
    chk("ramp output gaps", 32'(gaps), 32'd0);

    // output stalled: exactly two beats buffered
    m0.tready = 1'b0;
    s0.tvalid = 1'b1;
    acc = 0;
    for (int k = 0; k < 16; k++) d[k*16 +: 16] = 16'h1000 + 16'(k);
    s0.tdata = d;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      if (s0.tready) acc++;
      @(posedge aclk); #1;
      for (int k = 0; k < 16; k++) d[k*16 +: 16] = 16'h1000 + 16'(acc*16 + k);
      s0.tdata = d;
    end
    chk("stall accepts", 32'(acc), 32'd2);
    chk("stall ready low", s0.tready, 1'b0);
    s0.tvalid = 1'b0;
    out0 = n_out;
    m0.tready = 1'b1;
    drain("drain stall");
    chk("stall release outputs", 32'(n_out - out0), 32'd4);

    // random backpressure and input gaps
    fork
      begin
        for (int b = 0; b < 1500; b++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
          for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
          send_beat(d, t_acc);
        end
        ramp_on = 1'b0;
      end
      begin
        for (int c = 0; c < 40000 && exp_q.size() < 100000; c++) begin
          @(posedge aclk); #1;
          m0.tready = ($urandom_range(0, 99) < 30);
          if (c > 10 && s0.tvalid == 1'b0 && exp_q.size() == 0 && t_acc < 0) break;
        end
      end
    join_any
    disable fork;
    m0.tready = 1'b1;
    drain("drain random");

    // reset after slice 0 has left
    for (int k = 0; k < 16; k++) d[k*16 +: 16] = 16'h2000 + 16'(k);
    send_beat(d, t_acc);
    @(posedge aclk); #2;
    areset = 1'b1;
    #1;
    chk("async reset valid", m0.tvalid, 1'b0);
    chk("async reset ready", s0.tready, 1'b0);
    chk("async reset tfirst", m0.tfirst, 1'b0);
    exp_q.delete();
    #3 areset = 1'b0;
    for (int k = 0; k < 16; k++) d[k*16 +: 16] = 16'h3000 + 16'(k);
    send_beat(d, t_acc);
    chk("post reset valid", m0.tvalid, 1'b1);
    chk("post reset tfirst", m0.tfirst, 1'b1);
    chk("post reset data", m0.tdata, d[127:0]);
    drain("drain post reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
